// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 style CPU: widths, opcodes and the
// bit layout of the control word driven by the control unit.
package sap_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEPTH = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions inside the control word; halt rides along as the top bit.
    localparam int CW_MI  = 0;
    localparam int CW_RI  = 1;
    localparam int CW_RO  = 2;
    localparam int CW_II  = 3;
    localparam int CW_IO  = 4;
    localparam int CW_AI  = 5;
    localparam int CW_AO  = 6;
    localparam int CW_SMO = 7;
    localparam int CW_SU  = 8;
    localparam int CW_BI  = 9;
    localparam int CW_OI  = 10;
    localparam int CW_CE  = 11;
    localparam int CW_CO  = 12;
    localparam int CW_JE  = 13;
    localparam int CW_HLT = 14;
    localparam int CW_W   = 15;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_alu.sv
// Adder/subtractor feeding the bus through smo. For a subtract the carry
// output is the inverted borrow, i.e. 1 when a >= b.
module sap_alu
    import sap_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              su,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        if (su) begin
            sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            sum = {1'b0, a} + {1'b0, b};
        end
    end

    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: single 8-bit bus, PC, MAR, 16x8 RAM, IR, A/B, ALU, output
// register and flags, all steered by the control word each clock.
module sap_datapath
    import sap_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              mi,
    input  logic              ri,
    input  logic              ro,
    input  logic              ii,
    input  logic              io,
    input  logic              ai,
    input  logic              ao,
    input  logic              smo,
    input  logic              su,
    input  logic              bi,
    input  logic              oi,
    input  logic              ce,
    input  logic              co,
    input  logic              je,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              bus_conflict,
    output logic [ADDR_W-1:0] pc_value
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [DATA_W-1:0] bus_value;
    logic [2:0]        driver_count;
    logic [DATA_W-1:0] ram [RAM_DEPTH];

    sap_alu u_alu (
        .a      (reg_a),
        .b      (reg_b),
        .su     (su),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Fixed-priority bus mux so a bad control word still yields a defined value.
    always_comb begin
        if (ro) begin
            bus_value = ram[mar];
        end else if (smo) begin
            bus_value = alu_result;
        end else if (ao) begin
            bus_value = reg_a;
        end else if (io) begin
            bus_value = {4'h0, ir[3:0]};
        end else if (co) begin
            bus_value = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end else begin
            bus_value = '0;
        end
    end

    assign driver_count = {2'b00, ro} + {2'b00, smo} + {2'b00, ao}
                        + {2'b00, io} + {2'b00, co};
    assign bus_conflict = (driver_count > 3'd1);
    assign bus          = bus_value;
    assign opcode       = ir[7:4];
    assign pc_value     = pc;

    // The programming port ignores reset and halt so code can be loaded at any time.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            ram[prog_addr] <= prog_data;
        end else if (!reset && !halt && ri) begin
            ram[mar] <= bus_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            mar        <= '0;
            ir         <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            out_valid <= oi && !halt;
            if (!halt) begin
                if (je) begin
                    pc <= bus_value[ADDR_W-1:0];
                end else if (ce) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (mi) mar      <= bus_value[ADDR_W-1:0];
                if (ii) ir       <= bus_value;
                if (ai) reg_a    <= bus_value;
                if (bi) reg_b    <= bus_value;
                if (oi) out_data <= bus_value;
                if (smo && ai) begin
                    carry_flag <= alu_carry;
                    zero_flag  <= (bus_value == '0);
                end
            end
        end
    end

endmodule

// File: doc/sap_datapath.md
SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  rising edge is the only state-update edge; control word is stable by then.
- reset  in  1  synchronous, active-high.
- halt  in  1  inhibits every register and RAM update except the programming port.
- mi, ri, ro, ii, io, ai, ao, smo, su, bi, oi, ce, co, je  in  1 each  control lines, meanings in REQ-005 to REQ-016.
- prog_en  in  1  programming-port write strobe.
- prog_addr  in  4  programming-port RAM address.
- prog_data  in  8  programming-port RAM data.
- opcode  out  4  IR[7:4], fed to the control unit.
- bus  out  8  current value of the internal bus.
- out_data  out  8  output register.
- out_valid  out  1  one-cycle pulse after an output-register load.
- carry_flag  out  1  ALU carry/borrow from the last ALU write to A.
- zero_flag  out  1  set when the last ALU write to A produced 0.
- bus_conflict  out  1  combinational; high when more than one bus driver is asserted.
- pc_value  out  4  program counter, for debug.

Function
REQ-002 The bus SHALL be combinational and driven by exactly one source selected by ro, io, ao, smo, co; it SHALL read 8'h00 when no driver is asserted.
REQ-003 When several drivers are asserted, the bus SHALL use fixed priority ro > smo > ao > io > co, and bus_conflict SHALL be 1.
REQ-004 All register loads SHALL sample the bus value present before the edge; a register both driving and loading in one cycle retains its old value as the bus source.
REQ-005 PC (4 bit): ce increments it mod 16 (15 wraps to 0).
REQ-006 PC: je loads bus[3:0]; if je and ce are both asserted, je wins.
REQ-007 co SHALL drive {4'h0, PC}.
REQ-008 MAR (4 bit): mi loads bus[3:0].
REQ-009 RAM (16x8): ro drives RAM[MAR] via combinational read from the current MAR.
REQ-010 RAM: ri writes the bus value to RAM[MAR].
REQ-011 IR (8 bit): ii loads the bus.
REQ-012 IR: io drives {4'h0, IR[3:0]}.
REQ-013 opcode SHALL equal IR[7:4] continuously.
REQ-014 A and B (8 bit): ai and bi load the bus; ao drives A.
REQ-015 The ALU SHALL compute A+B (su=0) or A-B (su=1), mod 256, and smo SHALL drive the result.
REQ-016 carry: carry-out for an add, and 1 = no borrow (A>=B) for a subtract.
REQ-017 Flags SHALL update only on a cycle with smo and ai both asserted; zero_flag=1 when the loaded value is 0.
REQ-018 oi SHALL load out_data from the bus, and out_valid SHALL pulse high for exactly the following cycle.
REQ-019 With halt=1, PC, MAR, IR, A, B, flags, OUT and RAM writes via ri SHALL hold; the bus and bus_conflict SHALL remain combinational.
REQ-020 prog_en SHALL write prog_data to RAM[prog_addr] regardless of halt.
REQ-021 If prog_en and ri target the same cycle, prog_en wins and the ri write is dropped.
REQ-022 Latency: every load is visible one clock after the edge on which its control line was sampled; the ALU result is visible in the same cycle A/B change.

Reset
REQ-023 On reset=1 at a rising edge, PC, MAR, IR, A, B, out_data, carry_flag and zero_flag SHALL become 0 and out_valid 0.
REQ-024 Reset SHALL NOT clear RAM contents.
REQ-025 Reset SHALL override halt and all control lines in the same cycle.
REQ-026 A programming-port write coincident with reset SHALL still complete.

Structure
REQ-027 Opcode constants (NOP 0, LDA 1, ADD 2, SUB 3, STA 4, LDI 5, JMP 6, OUT 14, HLT 15) and control-word bit indices SHALL live in shared package sap_pkg, also used by the control unit.
REQ-028 The adder/subtractor with carry SHALL be a sub-module sap_alu; all other logic is in sap_datapath.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Fetch: RAM[0]=8'h1E via prog port; reset; co+mi+ce, then ro+ii -> MAR=0, PC=1, opcode=1, IR=8'h1E.
- ADD: A=8'hF0, RAM[5]=8'h20; io+mi (IR low=5), ro+bi, smo+ai -> A=8'h10, carry=1, zero=0.
- SUB to zero: A=8'h07, B=8'h07, smo+su+ai -> A=0, zero=1, carry=1; then A=3, B=5 SUB -> A=8'hFE, carry=0.
- PC wrap and jump: PC=15 with ce -> 0; ce+je with bus=9 (io, IR=8'h69) -> PC=9.
- Halt and conflict: halt=1 with ai+ao, ce, ri -> no state change; ro+ao together -> bus=RAM[MAR], bus_conflict=1.
- OUT and reset: A=8'h2A, ao+oi -> out_data=8'h2A, out_valid high one cycle; reset -> all registers 0, RAM[5] still 8'h20.
